// File: rtl/alu_acc_pkg.sv
// Shared opcode and FSM state encodings for the accumulator ALU (alu_acc_seq).
package alu_acc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_LOGIC = 3'b100,
    OP_XORX  = 3'b101,
    OP_SWAP  = 3'b110,
    OP_MUL   = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_acc_mul_core.sv
// Shift-add multiplier datapath: load latches operands, then one partial
// product per clock for OPND_W clocks; product is the post-step value.
module alu_acc_mul_core
  import alu_acc_pkg::*;
#(
  parameter  int unsigned OPND_W = 4,
  localparam int unsigned ACC_W  = 2 * OPND_W,
  localparam int unsigned CNT_W  = $clog2(OPND_W + 1)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              load,
  input  logic [OPND_W-1:0] mcand,
  input  logic [OPND_W-1:0] mplier,
  output logic [ACC_W-1:0]  product,
  output logic              last
);

  logic              run_q;
  logic [OPND_W-1:0] mcand_q;
  logic [OPND_W-1:0] mplier_q;
  logic [ACC_W-1:0]  prod_q;
  logic [CNT_W-1:0]  count_q;
  logic [ACC_W-1:0]  addend;

  // product already includes this cycle's partial term, so the owner can
  // capture the final result on the same edge that last is high.
  always_comb begin
    addend = '0;
    if (mplier_q[0]) begin
      addend = ACC_W'(mcand_q) << count_q;
    end
    product = prod_q + addend;
    last    = run_q && (count_q == CNT_W'(OPND_W - 1));
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      run_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
    end else if (load) begin
      run_q    <= 1'b1;
      mcand_q  <= mcand;
      mplier_q <= mplier;
      prod_q   <= '0;
      count_q  <= '0;
    end else if (run_q) begin
      prod_q   <= product;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + CNT_W'(1);
      if (last) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator ALU with start/busy/done handshake and multi-cycle multiply.
// Build option: ALU_ACC_SAT_EN makes SUB clamp to zero on borrow.
module alu_acc_seq
  import alu_acc_pkg::*;
#(
  parameter  int unsigned OPND_W = 4,
  localparam int unsigned ACC_W  = 2 * OPND_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [OPND_W-1:0] a,
  output logic [ACC_W-1:0]  acc,
  output logic              busy,
  output logic              done,
  output logic              carry,
  output logic              zero
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic               mul_load;
  logic [ACC_W-1:0]   mul_product;
  logic               mul_last;

  logic [OPND_W-1:0]  acc_lo;
  logic [ACC_W-1:0]   a_x, l_x, sum, diff;
  logic               borrow;

  alu_acc_mul_core #(
    .OPND_W (OPND_W)
  ) u_mul (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .load    (mul_load),
    .mcand   (a),
    .mplier  (acc_lo),
    .product (mul_product),
    .last    (mul_last)
  );

  always_comb begin
    acc_lo = acc_q[OPND_W-1:0];
    a_x    = ACC_W'(a);
    l_x    = ACC_W'(acc_lo);
    sum    = a_x + l_x;
    diff   = l_x - a_x;
    borrow = (a > acc_lo);

    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    mul_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          unique case (op_e'(op))
            OP_HOLD: ;
            OP_LOAD: begin
              acc_d   = a_x;
              carry_d = 1'b0;
            end
            OP_ADD: begin
              acc_d   = sum;
              carry_d = sum[OPND_W];
            end
            OP_SUB: begin
              carry_d = borrow;
`ifdef ALU_ACC_SAT_EN
              acc_d   = borrow ? '0 : diff;
`else
              acc_d   = diff;
`endif
            end
            OP_LOGIC: begin
              acc_d   = {~(a | acc_lo), ~(a & acc_lo)};
              carry_d = 1'b0;
            end
            OP_XORX: begin
              acc_d   = {a ^ acc_lo, ~(a ^ acc_lo)};
              carry_d = 1'b0;
            end
            OP_SWAP: begin
              acc_d   = {acc_lo, ~a};
              carry_d = 1'b0;
            end
            OP_MUL: begin
              // Multiply completes later; acc and flags hold until then.
              done_d   = 1'b0;
              mul_load = 1'b1;
              state_d  = ST_MUL;
            end
            default: ;
          endcase
          zero_d = (acc_d == '0);
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          acc_d   = mul_product;
          carry_d = 1'b0;
          zero_d  = (mul_product == '0);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign acc   = acc_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign done  = done_q;
  assign busy  = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_acc_seq.sv
// Randomized bench for alu_acc_seq against an arithmetic reference model.
module tb_alu_acc_seq;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned ACC_W  = 2 * OPND_W;
  localparam int unsigned LMASK  = (1 << OPND_W) - 1;
  localparam int unsigned AMASK  = (1 << ACC_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              start;
  logic [2:0]        op;
  logic [OPND_W-1:0] a;
  logic [ACC_W-1:0]  acc;
  logic              busy, done, carry, zero;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned m_acc = 0;
  int unsigned m_carry = 0;

  always #5 Clk = ~Clk;

  alu_acc_seq #(
    .OPND_W (OPND_W)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .acc     (acc),
    .busy    (busy),
    .done    (done),
    .carry   (carry),
    .zero    (zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int unsigned exp_busy, input int unsigned exp_done);
    check({tag, ".acc"},   32'(acc),   m_acc);
    check({tag, ".carry"}, 32'(carry), m_carry);
    check({tag, ".zero"},  32'(zero),  32'(m_acc == 0));
    check({tag, ".busy"},  32'(busy),  exp_busy);
    check({tag, ".done"},  32'(done),  exp_done);
  endtask

  // Reference semantics of the single-cycle opcodes on plain integers.
  function automatic void model(input int unsigned o, input int unsigned av);
    int unsigned l = m_acc & LMASK;
    int unsigned s;
    case (o)
      1: begin m_acc = av; m_carry = 0; end
      2: begin s = av + l; m_acc = s; m_carry = (s >> OPND_W) & 1; end
      3: begin
        if (av > l) begin
          m_carry = 1;
`ifdef ALU_ACC_SAT_EN
          m_acc = 0;
`else
          m_acc = (l + (1 << ACC_W) - av) & AMASK;
`endif
        end else begin
          m_carry = 0;
          m_acc   = l - av;
        end
      end
      4: begin m_acc = (((~(av | l)) & LMASK) << OPND_W) | ((~(av & l)) & LMASK); m_carry = 0; end
      5: begin m_acc = (((av ^ l) & LMASK) << OPND_W) | ((~(av ^ l)) & LMASK); m_carry = 0; end
      6: begin m_acc = (l << OPND_W) | ((~av) & LMASK); m_carry = 0; end
      default: ;
    endcase
  endfunction

  task automatic apply(input int unsigned o, input int unsigned av);
    int unsigned prod;
    start = 1'b1;
    op    = 3'(o);
    a     = OPND_W'(av);
    if (o != 7) begin
      tick();
      model(o, av);
      check_state("op", 0, 1);
    end else begin
      prod = av * (m_acc & LMASK);
      tick();
      check_state("mul_entry", 1, 0);
      for (int i = 1; i <= int'(OPND_W); i++) begin
        start = 1'b1;
        op    = 3'($urandom);
        a     = OPND_W'($urandom);
        if (i == 2) begin
          op = 3'd1;
          a  = OPND_W'(3);
        end
        tick();
        if (i < int'(OPND_W)) begin
          check_state("mul_run", 1, 0);
        end else begin
          m_acc   = prod;
          m_carry = 0;
          check_state("mul_done", 0, 1);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic idle();
    start = 1'b0;
    tick();
    check_state("idle", 0, 0);
  endtask

  initial begin
    int unsigned r, o, av;
    Reset_n = 1'b0;
    start   = 1'b1;
    op      = 3'd1;
    a       = OPND_W'(5);
    tick();
    Reset_n = 1'b1;
    start   = 1'b0;
    m_acc   = 0;
    m_carry = 0;
    check_state("reset", 0, 0);
    idle();

    apply(1, 9);
    check("plan_load", 32'(acc), 32'h09);
    apply(2, 15);
    check("plan_add", 32'(acc), 32'h18);
    check("plan_add_c", 32'(carry), 1);
    idle();

    apply(1, 2);
    apply(3, 5);
`ifdef ALU_ACC_SAT_EN
    check("plan_sub", 32'(acc), 32'h00);
`else
    check("plan_sub", 32'(acc), 32'hFD);
`endif
    check("plan_sub_c", 32'(carry), 1);
    idle();

    apply(1, 7);
    apply(7, 6);
    check("plan_mul", 32'(acc), 32'h2A);
    idle();

    // Reset asserted on the second multiply edge aborts without done.
    apply(1, 7);
    start = 1'b1;
    op    = 3'd7;
    a     = OPND_W'(6);
    tick();
    start = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 1);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    m_acc   = 0;
    m_carry = 0;
    check_state("mul_abort", 0, 0);
    idle();
    apply(1, 4);
    check("after_abort", 32'(acc), 32'h04);

    repeat (300) begin
      r = $urandom_range(0, 3);
      if (r == 0) idle();
      o  = $urandom_range(0, 7);
      av = $urandom_range(0, LMASK);
      apply(o, av);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
- Parametrised successor to the lab ALU-plus-register datapath: an accumulator ALU with a start/busy/done handshake.
- Adds a multi-cycle shift-add multiply, subtract with borrow, and registered carry/zero flags.
- The accumulator is internal and persistent. It sits between the switch/key input layer and the LED/7-seg display layer.

Parameters:
- OPND_W, 4, width of operand input a.
- ACC_W, localparam = 2*OPND_W, width of the accumulator. It is not overridable.
- CNT_W, localparam = $clog2(OPND_W+1), width of the multiply iteration counter.

Ports:
- Clk  input  1  clock; all state changes on posedge.
- Reset_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  opcode; sampled with start.
- a  input  OPND_W  operand; sampled with start.
- acc  output  ACC_W  accumulator value (registered).
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when acc/flags have been updated.
- carry  output  1  carry (ADD) or borrow (SUB) flag (registered).
- zero  output  1  registered; equals (acc == 0) after each update.

Behaviour:
- Reset: Reset_n=0 at a posedge forces state=IDLE, acc=0, busy=0, done=0, carry=0, zero=1. Reset dominates start and aborts an in-flight multiply; no done is issued.
- States: IDLE and MUL.
- accL denotes acc[OPND_W-1:0]. a and accL are zero-extended to ACC_W before arithmetic.
- Single-cycle ops: start=1 in IDLE at edge k means acc, carry and zero update at edge k, done=1 during cycle k+1 only, and the state stays IDLE.
- Back-to-back starts are legal: one op per cycle, one done per op.
- Opcodes:
  - 000 HOLD: acc unchanged; done still pulses; carry unchanged.
  - 001 LOAD: acc=zext(a); carry=0.
  - 010 ADD: acc=zext(a)+zext(accL); carry=bit OPND_W of the sum; upper bits are zero.
  - 011 SUB: acc=(zext(accL)-zext(a)) mod 2^ACC_W; carry=1 iff a>accL (borrow).
  - 100 LOGIC: acc={~(a|accL), ~(a&accL)}; carry=0.
  - 101 XORX: acc={a^accL, ~(a^accL)}; carry=0.
  - 110 SWAP: acc={accL, ~a}; carry=0.
  - 111 MUL: go to MUL.
- MUL entry (edge k): busy=1; latch mcand=a and mplier=accL; clear product and count.
- MUL iteration: each edge in MUL, if mplier[0] then product+=mcand<<count; mplier>>=1; count++.
- MUL completion: on the OPND_W-th edge in MUL, acc=product (full ACC_W result, no overflow possible), carry=0, busy=0, state=IDLE; done pulses in the following cycle.
  - Latency start-to-done: OPND_W+1 edges.
  - busy is high for OPND_W cycles.
- start, op and a are ignored while busy. Operand changes during MUL have no effect.
- In MUL, acc holds its old value until completion.
- done and busy are never high in the same cycle.

Optional Feature:
- Macro ALU_ACC_SAT_EN.
- Defined: SUB clamps the result to 0 on borrow (carry=1, acc=0, zero=1).
- Undefined: SUB wraps as specified above. Example with OPND_W=4: 2-5 gives acc=0xFD, carry=1.
- All other ops are identical in both builds.

Decomposition:
- Package alu_acc_pkg holds the 3-bit opcode constants (OP_HOLD..OP_MUL) and the state encoding (ST_IDLE, ST_MUL).
- One sub-module, alu_acc_mul_core, contains the shift-add multiplier datapath.
  - Inputs: Clk, Reset_n, load, mcand, mplier.
  - Outputs: product, last.
- The top level holds the FSM, the single-cycle op mux, the acc/flag registers and done generation.

Test Plan (OPND_W=4):
- Reset then idle: Reset_n=0 for one edge → acc=0x00, zero=1, carry=0, busy=0, done=0.
- LOAD a=9, then ADD a=0xF → after LOAD acc=0x09, done one cycle; after ADD acc=0x18, carry=1, zero=0.
- LOAD 2, then SUB a=5 → acc=0xFD, carry=1. With ALU_ACC_SAT_EN: acc=0x00, carry=1, zero=1.
- LOAD 7, then MUL a=6 → busy high 4 cycles, acc=0x07 throughout; acc=0x2A and done pulse on the cycle after busy falls.
- MUL in progress, assert start with op=LOAD a=3 while busy → ignored; final acc=product; exactly one done.
- MUL in progress, Reset_n=0 on the 2nd MUL edge → IDLE, acc=0, busy=0, no done; next LOAD 4 gives acc=0x04.
